// File: rtl/caesar_mem_port_arbiter.sv
// Caesar SRAM bank front end: host/engine port arbiter with retention sequencing.
// Optional CAESAR_ARB_ROUND_ROBIN_EN selects round-robin instead of cae-first priority.
module caesar_mem_port_arbiter #(
  parameter int NUM_WORDS   = 1024,
  parameter int DATA_WIDTH  = 32,
  parameter int WAKE_CYCLES = 4,
  localparam int AddrWidth  = (NUM_WORDS <= 1) ? 1 : $clog2(NUM_WORDS),
  localparam int BeWidth    = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  bus_req_i,
  output logic                  bus_gnt_o,
  input  logic                  bus_we_i,
  input  logic [AddrWidth-1:0]  bus_addr_i,
  input  logic [DATA_WIDTH-1:0] bus_wdata_i,
  input  logic [BeWidth-1:0]    bus_be_i,
  output logic                  bus_rvalid_o,
  output logic [DATA_WIDTH-1:0] bus_rdata_o,

  input  logic                  cae_req_i,
  output logic                  cae_gnt_o,
  input  logic                  cae_we_i,
  input  logic [AddrWidth-1:0]  cae_addr_i,
  input  logic [DATA_WIDTH-1:0] cae_wdata_i,
  input  logic [BeWidth-1:0]    cae_be_i,
  output logic                  cae_rvalid_o,
  output logic [DATA_WIDTH-1:0] cae_rdata_o,

  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [AddrWidth-1:0]  mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [BeWidth-1:0]    mem_be_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,

  output logic                  set_retentive_no,
  input  logic                  ret_req_i,
  output logic                  ret_ack_o
);

  localparam int CntW = (WAKE_CYCLES < 1) ? 1 : $clog2(WAKE_CYCLES + 1);

  typedef enum logic [1:0] {
    ACTIVE,
    DRAIN,
    RETENTIVE,
    WAKE
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] wake_cnt_q, wake_cnt_d;
  logic            set_ret_n_q, set_ret_n_d;
  logic            ret_ack_q, ret_ack_d;
  logic            bus_rvalid_q, bus_rvalid_d;
  logic            cae_rvalid_q, cae_rvalid_d;
  logic            rd_q, rd_d;

  logic            grant_ok;
  logic            cae_wins;

  // Grants are only legal in ACTIVE with no pending retention request.
  assign grant_ok = (state_q == ACTIVE) && !ret_req_i && !rst_i;

`ifdef CAESAR_ARB_ROUND_ROBIN_EN
  // rr_q = 0 favours bus on a tie, 1 favours cae.
  logic rr_q, rr_d;

  // Pointer flips toward the port that did not just win.
  always_comb begin
    rr_d = rr_q;
    if (bus_gnt_o) rr_d = 1'b1;
    if (cae_gnt_o) rr_d = 1'b0;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_q <= 1'b0;
    else       rr_q <= rr_d;
  end

  assign cae_wins = cae_req_i && !(bus_req_i && !rr_q);
`else
  assign cae_wins = cae_req_i;
`endif

  assign cae_gnt_o = grant_ok && cae_wins;
  assign bus_gnt_o = grant_ok && bus_req_i && !cae_wins;

  // Steer the winner onto the bank; idle bank sees all zeros.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (cae_gnt_o) begin
      mem_req_o   = 1'b1;
      mem_we_o    = cae_we_i;
      mem_addr_o  = cae_addr_i;
      mem_wdata_o = cae_wdata_i;
      mem_be_o    = cae_be_i;
    end else if (bus_gnt_o) begin
      mem_req_o   = 1'b1;
      mem_we_o    = bus_we_i;
      mem_addr_o  = bus_addr_i;
      mem_wdata_o = bus_wdata_i;
      mem_be_o    = bus_be_i;
    end
  end

  // Retention sequencing and one-deep response tracking.
  always_comb begin
    state_d      = state_q;
    wake_cnt_d   = wake_cnt_q;
    set_ret_n_d  = set_ret_n_q;
    ret_ack_d    = ret_ack_q;
    bus_rvalid_d = bus_gnt_o;
    cae_rvalid_d = cae_gnt_o;
    rd_d         = (bus_gnt_o && !bus_we_i) ||
                   (cae_gnt_o && !cae_we_i);
    unique case (state_q)
      ACTIVE: begin
        if (ret_req_i) state_d = DRAIN;
      end
      DRAIN: begin
        state_d     = RETENTIVE;
        set_ret_n_d = 1'b0;
        ret_ack_d   = 1'b1;
      end
      RETENTIVE: begin
        if (!ret_req_i) begin
          state_d     = WAKE;
          wake_cnt_d  = CntW'(WAKE_CYCLES);
          set_ret_n_d = 1'b1;
          ret_ack_d   = 1'b0;
        end
      end
      WAKE: begin
        if (wake_cnt_q == '0) state_d = ACTIVE;
        else wake_cnt_d = wake_cnt_q - 1'b1;
      end
      default: state_d = ACTIVE;
    endcase
  end

  // State and response registers; reset drops any in-flight response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ACTIVE;
      wake_cnt_q   <= '0;
      set_ret_n_q  <= 1'b1;
      ret_ack_q    <= 1'b0;
      bus_rvalid_q <= 1'b0;
      cae_rvalid_q <= 1'b0;
      rd_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      wake_cnt_q   <= wake_cnt_d;
      set_ret_n_q  <= set_ret_n_d;
      ret_ack_q    <= ret_ack_d;
      bus_rvalid_q <= bus_rvalid_d;
      cae_rvalid_q <= cae_rvalid_d;
      rd_q         <= rd_d;
    end
  end

  assign bus_rvalid_o     = bus_rvalid_q;
  assign cae_rvalid_o     = cae_rvalid_q;
  assign bus_rdata_o      = (bus_rvalid_q && rd_q) ? mem_rdata_i : '0;
  assign cae_rdata_o      = (cae_rvalid_q && rd_q) ? mem_rdata_i : '0;
  assign set_retentive_no = set_ret_n_q;
  assign ret_ack_o        = ret_ack_q;

endmodule
